// File: rtl/instr_mem_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction memory,
// pads the rest with NOPs and holds the CPU in reset until the image is complete.
module instr_mem_loader #(
  parameter int unsigned DEPTH    = 128,
  parameter logic [31:0] NOP_WORD = 32'b1101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n,
  output logic [7:0]  words_loaded
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_PAD, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   n_q, n_d, n_full;
  logic [31:0]        word_q, word_d;
  logic [1:0]         k_q, k_d;
  logic               xfer;
  logic               byte_ready_d, mem_we_d, busy_d, done_d, error_d, cpu_rst_n_d;
  logic [31:0]        mem_waddr_d, mem_wdata_d;

  assign xfer   = byte_valid && byte_ready;
  assign n_full = {byte_data, n_q[7:0]};

  // Next-state, datapath and next-output decode; outputs are registered below.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = words_loaded;
    n_d     = n_q;
    word_d  = word_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          idx_d   = '0;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = byte_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = n_full;
          if (n_full > CNT_W'(DEPTH))  state_d = S_ERR;
          else if (n_full == '0)       state_d = S_PAD;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          unique case (k_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            2'd3: word_d[31:24] = byte_data;
          endcase
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        cnt_d = words_loaded + IDX_W'(1);
        if (CNT_W'(idx_q) == n_q - CNT_W'(1))
          state_d = (n_q < CNT_W'(DEPTH)) ? S_PAD : S_DONE;
        else
          state_d = S_DATA;
      end
      S_PAD: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DEPTH - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
    mem_we_d     = (state_d == S_WRITE) || (state_d == S_PAD);
    busy_d       = byte_ready_d || mem_we_d;
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    cpu_rst_n_d  = done_d;
    mem_waddr_d  = mem_waddr;
    mem_wdata_d  = mem_wdata;
    if (mem_we_d) begin
      mem_waddr_d = 32'({idx_d[AW-1:0], 2'b00});
      mem_wdata_d = (state_d == S_PAD) ? NOP_WORD : word_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      word_q       <= '0;
      k_q          <= '0;
      words_loaded <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst_n    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      word_q       <= word_d;
      k_q          <= k_d;
      words_loaded <= cnt_d;
      byte_ready   <= byte_ready_d;
      mem_we       <= mem_we_d;
      mem_waddr    <= mem_waddr_d;
      mem_wdata    <= mem_wdata_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      cpu_rst_n    <= cpu_rst_n_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the stimulus
// and consumed by an independent write monitor.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, busy, done, error, cpu_rst_n;
  logic [31:0] mem_waddr, mem_wdata;
  logic [7:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  int          exp_idx;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .cpu_rst_n(cpu_rst_n), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got @%h=%h expected @%h=%h", mem_waddr, mem_wdata, e[63:32], e[31:0]);
        end
      end
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic new_image();
    stim.delete();
    exp_idx = 0;
  endtask

  task automatic add_hdr(input logic [15:0] n);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(8'(w >> (8 * b)));
    exp_q.push_back({32'(exp_idx * 4), w});
    exp_idx++;
  endtask

  task automatic expect_pad();
    for (int i = exp_idx; i < 128; i++) exp_q.push_back({32'(i * 4), 32'h0000000D});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends stim bytes; with gap set, byte_valid drops for one cycle after each transfer.
  task automatic send_stream(input bit gap);
    foreach (stim[i]) begin
      int waited = 0;
      byte_valid = 1'b1;
      byte_data  = stim[i];
      forever begin
        @(negedge clk);
        if (byte_ready) break;
        waited++;
        if (waited > 50) begin
          $display("FAIL byte_timeout: byte %0d never accepted", i);
          $fatal(1);
        end
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("end_reached", 32'(done || error), 32'd1);
  endtask

  task automatic check_done(input logic [7:0] wl);
    check("done", 32'(done), 32'd1);
    check("cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(wl));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_waddr"}, mem_waddr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_flags"}, {28'd0, busy, done, error, cpu_rst_n}, 32'd0);
    check({tag, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic load_test1();
    new_image();
    add_hdr(16'd2);
    add_word(32'h00A00513);
    add_word(32'h00100593);
    expect_pad();
    pulse_start();
    send_stream(1'b0);
    wait_end();
    check_done(8'd2);
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    // Two-word image, then pad.
    load_test1();

    // Empty image: pad only; cpu_rst_n drops on the start edge.
    new_image();
    add_hdr(16'd0);
    expect_pad();
    pulse_start();
    check("start_drops_cpu_rst", 32'(cpu_rst_n), 32'd0);
    check("busy_hdr0", 32'(busy), 32'd1);
    send_stream(1'b0);
    wait_end();
    check_done(8'd0);

    // Oversized count goes to ERR, then recovers with a one-word image.
    new_image();
    add_hdr(16'd129);
    pulse_start();
    send_stream(1'b0);
    check("err_flag", 32'(error), 32'd1);
    check("err_ready", 32'(byte_ready), 32'd0);
    check("err_cpu_rst", 32'(cpu_rst_n), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("err_stays", 32'(error), 32'd1);
    new_image();
    add_hdr(16'd1);
    add_word(32'hDEADBEEF);
    expect_pad();
    pulse_start();
    send_stream(1'b0);
    wait_end();
    check_done(8'd1);

    // One-word image with byte_valid toggling.
    new_image();
    add_hdr(16'd1);
    add_word(32'h12345678);
    expect_pad();
    pulse_start();
    send_stream(1'b1);
    wait_end();
    check_done(8'd1);

    // Full image: no pad, DONE the edge after the last write.
    new_image();
    add_hdr(16'd128);
    for (int i = 0; i < 128; i++) add_word(32'hA5000000 | 32'(i * 3));
    pulse_start();
    send_stream(1'b0);
    check("full_last_we", 32'(mem_we), 32'd1);
    check("full_last_addr", mem_waddr, 32'd508);
    check("full_not_done_yet", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_done(8'd128);

    // Reset in the middle of a load, then a clean reload.
    new_image();
    stim.push_back(8'h02); stim.push_back(8'h00);
    stim.push_back(8'h13); stim.push_back(8'h05);
    pulse_start();
    send_stream(1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_test1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side companion to the instruction memory: receives a byte stream with a valid/ready handshake, assembles little-endian 32-bit instructions and writes them word by word into the instruction memory's write port. Unloaded words are then padded with the NOP encoding 32'b1101. The CPU is held in reset until loading completes. It sits between the host/boot link and the instruction memory, replacing file-based preload for hardware runs.

## Interface
- DEPTH, 128, number of 32-bit words in instruction memory
- NOP_WORD, 32'b1101, fill value for words beyond the loaded image

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse to begin a load; honoured only in IDLE, DONE, ERR
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_waddr  out  32  byte address (word index << 2), same addressing as PC
- mem_wdata  out  32  instruction word
- busy  out  1  high in HDR0, HDR1, DATA, WRITE, PAD
- done  out  1  high in DONE
- error  out  1  high in ERR
- cpu_rst_n  out  1  CPU reset release; high only in DONE
- words_loaded  out  8  data words written from the stream in the current load (pad words excluded)

## Operation
- Stream format: 2-byte little-endian word count N, then 4N bytes, each instruction least-significant byte first.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_valid may drop at any time. Stalls do not corrupt state.
- States:
  - IDLE: byte_ready=0. start -> HDR0, clear words_loaded and the word index.
  - HDR0: byte_ready=1. Transfer -> N[7:0], go to HDR1.
  - HDR1: byte_ready=1. Transfer -> N[15:8]. If N > DEPTH -> ERR. If N == 0 -> PAD. Otherwise -> DATA.
  - DATA: byte_ready=1. The k-th byte (k=0..3) goes to word bits [8k+7:8k]. The 4th transfer -> WRITE.
  - WRITE: byte_ready=0. mem_we=1, mem_waddr=idx<<2, mem_wdata=assembled word. idx++ and words_loaded++. If idx was N-1, go to PAD if N<DEPTH, else DONE. Otherwise -> DATA.
  - PAD: byte_ready=0. mem_we=1, mem_wdata=NOP_WORD, mem_waddr=idx<<2, idx++ each cycle. After writing index DEPTH-1 -> DONE.
  - DONE: done=1, cpu_rst_n=1. start -> HDR0, with cpu_rst_n dropping in the same edge.
  - ERR: error=1, cpu_rst_n=0, no writes. start -> HDR0.
- start is ignored in HDR0, HDR1, DATA, WRITE and PAD.
- Counters: idx and words_loaded are 8 bits wide. N is compared as 16 bits, so N in 129..65535 always means ERR.
- mem_waddr[31:9] is always 0 and mem_waddr[1:0] is always 0.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, byte_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, busy 0, done 0, error 0, cpu_rst_n 0, words_loaded 0, idx 0, N 0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Write latency: mem_we is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- Peak throughput: 1 word per 5 cycles in DATA/WRITE. Pad rate: 1 word per cycle.
- Reset asserted mid-load returns to IDLE with reset values. Memory contents are then unspecified, but cpu_rst_n stays 0.
- Reaching DONE from DATA with a partial word is impossible. A load ends only on a complete count.

## Test plan
- N=2, bytes 02 00 13 05 A0 00 93 05 10 00 (byte_valid held high):
  - writes 0x00A00513 @0 and 0x00100593 @4;
  - then 126 consecutive writes of 0x0000000D @8..@508;
  - then done=1, cpu_rst_n=1, words_loaded=2.
- N=0 (00 00): no data writes; 128 pad writes @0..@508; DONE.
- N=129 (81 00): ERR on the edge after the 2nd byte, error=1, byte_ready=0, mem_we never asserted. A later start followed by a valid N=1 image completes normally.
- N=1, byte_valid toggled every other cycle: same single write as with byte_valid held. byte_ready=0 during the WRITE cycle and throughout PAD.
- N=128 full image: last data write @508, zero pad writes, DONE on the edge after that write.
- rst_n pulsed low after the 2nd data byte of N=2: all outputs at reset values immediately; IDLE. A new start plus the full stream reproduces the first test's writes.
